logit_inv: RTL and testbench

LOGIT_INV -- requirements
Module: logit_inv

---
 rtl/logit_inv.sv | 125 ++++++++++++
 tb/tb_logit_inv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/logit_inv.sv
// Inverse-sigmoid (logit) by 8-step bisection over a piecewise-linear sigmoid.
// Define LOGIT_CLAMP_EN to clamp p > 1.0 instead of flagging it on err.
module logit_inv (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       p_valid,
   output logic       p_ready,
   input  logic [7:0] p,
   output logic       x_valid,
   input  logic       x_ready,
   output logic [7:0] x,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, SEARCH, FIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic signed [7:0] lo_q, lo_d;
   logic signed [7:0] hi_q, hi_d;
   logic [7:0]        p_q, p_d;
   logic [7:0]        x_q, x_d;
   logic              err_q, err_d;

   logic signed [8:0] sum;
   logic signed [7:0] mid;
   logic              pbig;
   logic [7:0]        pc;
   logic [8:0]        ptgt;
   logic              ge;

   function automatic logic [8:0] sig(input logic signed [7:0] c);
      logic [7:0] a;
      logic [8:0] s;
      a = c[7] ? 8'(-c) : 8'(c);
      if (a >= 8'd80)
         s = 9'd256;
      else if (a >= 8'd38)
         s = {2'b00, a[7:1]} + 9'd216;
      else if (a >= 8'd16)
         s = {a, 1'b0} + 9'd160;
      else
         s = {a[6:0], 2'b00} + 9'd128;
      return c[7] ? 9'd256 - s : s;
   endfunction

   // floor((lo+hi)/2): drop the LSB of the sign-extended sum
   assign sum  = {lo_q[7], lo_q} + {hi_q[7], hi_q};
   assign mid  = sum[8:1];
   assign pbig = p_q > 8'd16;
   assign pc   = pbig ? 8'd16 : p_q;
   assign ptgt = {pc[4:0], 4'b0000};
   assign ge   = sig(mid) >= ptgt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         p_q     <= '0;
         x_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         p_q     <= p_d;
         x_q     <= x_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (p_valid) state_d = SEARCH;
         SEARCH:  if (cnt_q == 3'd7) state_d = FIN;
         FIN:     state_d = DONE;
         DONE:    if (x_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      lo_d  = lo_q;
      hi_d  = hi_q;
      p_d   = p_q;
      x_d   = x_q;
      err_d = err_q;
      unique case (state_q)
         IDLE: begin
            if (p_valid) begin
               p_d   = p;
               lo_d  = -8'sd128;
               hi_d  = 8'sd127;
               cnt_d = '0;
            end
         end
         SEARCH: begin
            if (ge) hi_d = mid;
            else    lo_d = mid + 8'sd1;
            cnt_d = cnt_q + 3'd1;
         end
         FIN: begin
`ifdef LOGIT_CLAMP_EN
            x_d   = lo_q;
            err_d = 1'b0;
`else
            x_d   = pbig ? 8'h7F : lo_q;
            err_d = pbig;
`endif
         end
         default: ;
      endcase
   end

   assign p_ready = (state_q == IDLE);
   assign x_valid = (state_q == DONE);
   assign x       = x_q;
   assign err     = err_q;

endmodule

// File: tb/tb_logit_inv.sv
// Scoreboard bench for logit_inv: fixed vectors, back-pressure, mid-search
// reset and a full p = 0..16 sweep against a linear-scan reference.
module tb_logit_inv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       p_valid = 1'b0;
   logic       p_ready;
   logic [7:0] p = 8'h00;
   logic       x_valid;
   logic       x_ready = 1'b0;
   logic [7:0] x;
   logic       err;

   int errors = 0;
   int checks = 0;
   logic [8:0] sb[$];

   logit_inv dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .p_valid (p_valid),
      .p_ready (p_ready),
      .p       (p),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .x       (x),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic int sref(int c);
      int a;
      int s;
      a = (c < 0) ? -c : c;
      if (a >= 80)      s = 256;
      else if (a >= 38) s = a / 2 + 216;
      else if (a >= 16) s = 2 * a + 160;
      else              s = 4 * a + 128;
      return (c < 0) ? 256 - s : s;
   endfunction

   // {err, x} expected for operand v
   function automatic logic [8:0] model(int v);
      int pv;
      int c;
      logic [7:0] r;
      pv = v;
`ifndef LOGIT_CLAMP_EN
      if (pv > 16) return {1'b1, 8'h7F};
`endif
      if (pv > 16) pv = 16;
      r = 8'h7F;
      for (c = -128; c <= 127; c++) begin
         if (sref(c) >= pv * 16) begin
            r = 8'(c);
            break;
         end
      end
      return {1'b0, r};
   endfunction

   task automatic do_op(input logic [7:0] v, input logic [8:0] exp,
                        input int stall, output logic [7:0] xo);
      int n;
      logic [8:0] got;
      logic [8:0] e;
      n = 0;
      while (!p_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!p_ready) begin
         errors++;
         $display("FAIL p_ready_wait p=%h: p_ready=%b want 1", v, p_ready);
      end
      p = v;
      p_valid = 1'b1;
      sb.push_back(exp);
      @(posedge clk); #1;
      p_valid = 1'b0;
      p = 8'hAA;
      checks++;
      if (p_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_ready p=%h: p_ready=%b want 0", v, p_ready);
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!x_valid && n < 30);
      e = sb.pop_front();
      checks++;
      if (n !== 9 || x_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency p=%h: edges=%0d x_valid=%b want 9/1",
                  v, n, x_valid);
      end
      got = {err, x};
      xo = x;
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL result p=%h: err,x=%b,%h want %b,%h",
                  v, got[8], got[7:0], e[8], e[7:0]);
      end
      for (int i = 0; i < stall; i++) begin
         p_valid = i[0];
         p = 8'h33;
         @(posedge clk); #1;
         checks++;
         if (x_valid !== 1'b1 || {err, x} !== got || p_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall%0d p=%h: v=%b err,x=%b,%h rdy=%b want 1 %b,%h 0",
                     i, v, x_valid, err, x, p_ready, got[8], got[7:0]);
         end
      end
      p_valid = 1'b0;
      x_ready = 1'b1;
      @(posedge clk); #1;
      x_ready = 1'b0;
      checks++;
      if (x_valid !== 1'b0 || p_ready !== 1'b1) begin
         errors++;
         $display("FAIL release p=%h: x_valid=%b p_ready=%b want 0/1",
                  v, x_valid, p_ready);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({x_valid, p_ready, err, x} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset: v=%b rdy=%b err=%b x=%h want 0 1 0 00",
                  x_valid, p_ready, err, x);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [7:0] xo;
      do_op(8'h08, {1'b0, 8'h00}, 0, xo);
      do_op(8'h00, {1'b0, 8'h80}, 0, xo);
      do_op(8'h10, {1'b0, 8'h50}, 0, xo);
      do_op(8'h0C, {1'b0, 8'h10}, 0, xo);
   endtask

   task automatic test_back_pressure();
      logic [7:0] xo;
      do_op(8'h0C, {1'b0, 8'h10}, 5, xo);
      do_op(8'h00, {1'b0, 8'h80}, 0, xo);
   endtask

   task automatic test_out_of_range();
      logic [7:0] xo;
`ifdef LOGIT_CLAMP_EN
      do_op(8'h11, {1'b0, 8'h50}, 0, xo);
`else
      do_op(8'h11, {1'b1, 8'h7F}, 0, xo);
`endif
      do_op(8'hFF, model(255), 0, xo);
   endtask

   task automatic test_reset_mid();
      logic [7:0] xo;
      int seen;
      do_op(8'h0C, {1'b0, 8'h10}, 0, xo);
      p = 8'h0C;
      p_valid = 1'b1;
      @(posedge clk); #1;
      p_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({x_valid, err, x} !== {1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid: v=%b err=%b x=%h want 0 0 00",
                  x_valid, err, x);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (x_valid) seen++;
      end
      checks++;
      if (seen !== 0 || p_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_discard: x_valid cycles=%0d rdy=%b want 0/1",
                  seen, p_ready);
      end
      do_op(8'h08, {1'b0, 8'h00}, 0, xo);
   endtask

   task automatic test_sweep();
      logic [7:0] xo;
      int prev;
      prev = -129;
      for (int v = 0; v <= 16; v++) begin
         do_op(8'(v), model(v), 0, xo);
         checks++;
         if ($signed(xo) < prev) begin
            errors++;
            $display("FAIL monotonic p=%0d: x=%0d prev=%0d",
                     v, $signed(xo), prev);
         end
         prev = $signed(xo);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_pressure();
      test_out_of_range();
      test_reset_mid();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

endmodule
